// File: rtl/add_7_bit.sv
// 7-bit unsigned ripple-carry adder with registered sum and carry-out.
// Operands are sampled on every rising clk edge; results appear one cycle later.
module add_7_bit #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             carry_d;
    logic             carry_q;

    // Full-adder chain; c[0] is tied low since there is no carry-in.
    always_comb begin
        c     = '0;
        sum_d = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum_d[i] = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        carry_d = c[WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign sum   = sum_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_add_7_bit.sv
// Self-checking bench for add_7_bit: directed corner cases, async reset,
// back-to-back throughput, stability between edges and random pairs.
module tb_add_7_bit;

    logic       clk;
    logic       rst;
    logic [6:0] a;
    logic [6:0] b;
    logic [6:0] sum;
    logic       carry;

    int n_cmp = 0;
    int n_err = 0;

    add_7_bit #(.WIDTH(7)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer addition of two unsigned 7-bit operands.
    function automatic logic [7:0] ref_add(input int unsigned x, input int unsigned y);
        int unsigned total;
        total = (x % 128) + (y % 128);
        return total[7:0];
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed carry=%0d sum=%0d, expected carry=%0d sum=%0d",
                   tag, obs[7], obs[6:0], exp[7], exp[6:0]);
        end
    endtask

    // Drive one operand pair in the low phase, check the result just after the edge.
    task automatic apply(input int unsigned xa, input int unsigned xb, input string tag);
        @(negedge clk);
        a = 7'(xa);
        b = 7'(xb);
        @(posedge clk);
        #1;
        check(tag, {carry, sum}, ref_add(xa, xb));
    endtask

    initial begin
        logic [7:0]  held;
        int unsigned ra;
        int unsigned rb;

        rst = 1'b1;
        a   = 7'd0;
        b   = 7'd0;
        #1;
        check("reset_at_start", {carry, sum}, 8'd0);
        @(posedge clk);
        #1;
        check("reset_held", {carry, sum}, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        apply(0, 0, "zero");
        apply(45, 0, "identity");
        apply(64, 63, "no_carry_max");
        apply(64, 64, "carry_b6");
        apply(127, 1, "carry_ripple");
        apply(127, 127, "maximum");

        apply(10, 20, "b2b_0");
        apply(100, 100, "b2b_1");
        apply(1, 126, "b2b_2");

        // Asynchronous reset in the middle of the low phase with a result in flight.
        apply(3, 4, "pre_reset");
        @(negedge clk);
        a = 7'd100;
        b = 7'd50;
        #2;
        rst = 1'b1;
        #1;
        check("reset_async", {carry, sum}, 8'd0);
        @(posedge clk);
        #1;
        check("reset_hold_edge", {carry, sum}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_release", {carry, sum}, ref_add(100, 50));

        // Inputs toggling between edges must not disturb the registered result.
        for (int i = 0; i < 4; i++) begin
            ra = $urandom_range(0, 127);
            rb = $urandom_range(0, 127);
            apply(ra, rb, "stable_base");
            held = ref_add(ra, rb);
            #1;
            a = 7'($urandom);
            b = 7'($urandom);
            #1;
            check("stable_mid1", {carry, sum}, held);
            a = ~a;
            b = ~b;
            #1;
            check("stable_mid2", {carry, sum}, held);
        end

        for (int i = 0; i < 24; i++) begin
            ra = $urandom_range(0, 127);
            rb = $urandom_range(0, 127);
            apply(ra, rb, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
